// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants and types for the instruction fetch unit.
//   IFU_ADDR_W / IFU_DATA_W : default fetch address and instruction widths
//   IFU_NOP                 : instruction substituted on a bus error (addi x0,x0,0)
//   ifu_entry_t             : instruction buffer entry {pc, instr, err}
package ifu_pkg;

    localparam int IFU_ADDR_W = 32;
    localparam int IFU_DATA_W = 32;

    localparam logic [IFU_DATA_W-1:0] IFU_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [IFU_ADDR_W-1:0] pc;
        logic [IFU_DATA_W-1:0] instr;
        logic                  err;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fetch_if.sv
// ifu_fetch_if: ICB instruction-memory bus between the fetch stage and memory.
//   cmd_valid/cmd_ready/cmd_addr/cmd_read : read command channel (master drives valid/addr/read)
//   rsp_valid/rsp_ready/rsp_rdata/rsp_err : read response channel (slave drives valid/data/err)
// Modports: master = fetch stage, slave = instruction memory.
interface ifu_fetch_if
    import ifu_pkg::*;
#(
    parameter int ADDR_W = IFU_ADDR_W,
    parameter int DATA_W = IFU_DATA_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_read;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_addr, cmd_read, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_addr, cmd_read, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/ifu_sync_fifo.sv
// ifu_sync_fifo: generic synchronous FIFO with flush.
//   clk, rstn : clock, async active-low reset (clears pointers, count and storage)
//   push, din : write din at tail
//   pop, dout : dout is the head entry; pop advances it
//   flush     : empties the FIFO on the next edge (overrides push/pop)
//   count     : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// Push while full is legal only together with a pop.
module ifu_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign count = cnt;

    a_no_underflow : assert property (@(posedge clk) disable iff (!rstn)
        !(pop && !flush && cnt == '0));
    a_no_overflow : assert property (@(posedge clk) disable iff (!rstn)
        !(push && !pop && !flush && cnt == CNT_W'(DEPTH)));

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch stage between the PC register and decode.
//   clk, rstn             : clock, async active-low reset
//   pc_ifu_addr           : fetch PC from the PC stage
//   ifu_pc_icb_cmd_ready  : command accepted this cycle, PC stage advances PC+4
//   ctrl_ifu_flush        : redirect, drop buffered and in-flight fetches
//   ctrl_ifu_stall        : issue no new commands
//   icb                   : ICB master port to instruction memory
//   ifu_dec_valid/ready   : decode handshake
//   ifu_dec_instr/pc/err  : head of the instruction buffer
// Each command pushes its PC into an address queue; the matching response pops
// it, so every instruction is delivered with its own PC. Issue is credit-limited
// to DEPTH (in-flight + buffered), which is why the response channel can always
// be ready.
module ifu_fetch
    import ifu_pkg::*;
#(
    parameter int ADDR_W = IFU_ADDR_W,
    parameter int DATA_W = IFU_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [ADDR_W-1:0] pc_ifu_addr,
    output logic              ifu_pc_icb_cmd_ready,
    input  logic              ctrl_ifu_flush,
    input  logic              ctrl_ifu_stall,
    ifu_fetch_if.master       icb,
    output logic              ifu_dec_valid,
    input  logic              ifu_dec_ready,
    output logic [DATA_W-1:0] ifu_dec_instr,
    output logic [ADDR_W-1:0] ifu_dec_pc,
    output logic              ifu_dec_err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int ENT_W = $bits(ifu_entry_t);

    logic             run_q;
    logic [CNT_W-1:0] outstd;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] buf_cnt;
    logic [CNT_W-1:0] aq_cnt;
    logic [CNT_W:0]   credit_used;

    logic             cmd_valid;
    logic             cmd_hs;
    logic             rsp_hs;
    logic             drop_rsp;
    logic             buf_push;
    logic             buf_pop;

    logic [ADDR_W-1:0] rsp_pc;
    ifu_entry_t        rsp_ent;
    ifu_entry_t        head_ent;

    // run_q keeps the bus quiet for the first edge out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    assign credit_used = {1'b0, outstd} + {1'b0, buf_cnt};
    assign cmd_valid   = run_q && !ctrl_ifu_flush && !ctrl_ifu_stall
                         && (credit_used < (CNT_W+1)'(DEPTH));

    assign cmd_hs   = cmd_valid && icb.cmd_ready;
    assign rsp_hs   = icb.rsp_valid && icb.rsp_ready;
    assign drop_rsp = rsp_hs && (drop_cnt != '0);
    // A response landing in a flush cycle is stale as well.
    assign buf_push = rsp_hs && !drop_rsp && !ctrl_ifu_flush;
    assign buf_pop  = ifu_dec_valid && ifu_dec_ready;

    assign icb.cmd_valid       = cmd_valid;
    assign icb.cmd_addr        = pc_ifu_addr;
    assign icb.cmd_read        = 1'b1;
    assign icb.rsp_ready       = run_q;
    assign ifu_pc_icb_cmd_ready = cmd_hs;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstd   <= '0;
            drop_cnt <= '0;
        end else begin
            outstd <= outstd + CNT_W'(cmd_hs) - CNT_W'(rsp_hs);
            // No command can issue during flush, so everything still
            // outstanding after this cycle's response must be dropped.
            if (ctrl_ifu_flush) begin
                drop_cnt <= outstd - CNT_W'(rsp_hs);
            end else if (drop_rsp) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    // The address queue is never flushed: stale fetches still need their
    // slot popped when their responses return.
    ifu_sync_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_addr_q (
        .clk   (clk),
        .rstn  (rstn),
        .push  (cmd_hs),
        .pop   (rsp_hs),
        .flush (1'b0),
        .din   (pc_ifu_addr),
        .dout  (rsp_pc),
        .count (aq_cnt)
    );

    always_comb begin
        rsp_ent       = '0;
        rsp_ent.pc    = rsp_pc;
        rsp_ent.instr = icb.rsp_err ? IFU_NOP : icb.rsp_rdata;
        rsp_ent.err   = icb.rsp_err;
    end

    ifu_sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_instr_buf (
        .clk   (clk),
        .rstn  (rstn),
        .push  (buf_push),
        .pop   (buf_pop),
        .flush (ctrl_ifu_flush),
        .din   (rsp_ent),
        .dout  (head_ent),
        .count (buf_cnt)
    );

    assign ifu_dec_valid = (buf_cnt != '0);
    assign ifu_dec_instr = head_ent.instr;
    assign ifu_dec_pc    = head_ent.pc;
    assign ifu_dec_err   = head_ent.err;

    a_outstd_max : assert property (@(posedge clk) disable iff (!rstn)
        outstd <= CNT_W'(DEPTH));
    a_drop_le_outstd : assert property (@(posedge clk) disable iff (!rstn)
        drop_cnt <= outstd);
    a_addr_q_tracks : assert property (@(posedge clk) disable iff (!rstn)
        aq_cnt == outstd);
    a_no_orphan_rsp : assert property (@(posedge clk) disable iff (!rstn)
        rsp_hs |-> (outstd != '0));

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] ERR_PC = 32'h0000_0020;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc;
    logic        flush;
    logic        stall;
    logic        dec_ready;
    logic        pc_ready;
    logic        dec_valid;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        dec_err;

    ifu_fetch_if #(.ADDR_W(32), .DATA_W(32)) icb ();

    ifu_fetch #(
        .ADDR_W (32),
        .DATA_W (32),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .pc_ifu_addr          (pc),
        .ifu_pc_icb_cmd_ready (pc_ready),
        .ctrl_ifu_flush       (flush),
        .ctrl_ifu_stall       (stall),
        .icb                  (icb),
        .ifu_dec_valid        (dec_valid),
        .ifu_dec_ready        (dec_ready),
        .ifu_dec_instr        (dec_instr),
        .ifu_dec_pc           (dec_pc),
        .ifu_dec_err          (dec_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit model_on = 1'b0;
    bit rsp_hold = 1'b0;

    typedef struct {
        logic [31:0] pc;
        bit          stale;
    } fl_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        err;
    } ex_t;

    fl_t mem_q[$];
    ex_t exp_q[$];

    bit  m_cv;
    fl_t m_h;
    ex_t m_e;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    // Instruction memory: in-order, responds the cycle after the command
    // unless rsp_hold is set.
    initial begin
        icb.rsp_valid = 1'b0;
        icb.rsp_rdata = '0;
        icb.rsp_err   = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rstn) begin
                mem_q.delete();
                exp_q.delete();
                icb.rsp_valid = 1'($urandom);
                icb.rsp_rdata = $urandom;
                icb.rsp_err   = 1'($urandom);
            end else if (mem_q.size() > 0 && !rsp_hold) begin
                icb.rsp_valid = 1'b1;
                icb.rsp_rdata = mem_word(mem_q[0].pc);
                icb.rsp_err   = (mem_q[0].pc == ERR_PC);
            end else begin
                icb.rsp_valid = 1'b0;
                icb.rsp_rdata = $urandom;
                icb.rsp_err   = 1'b0;
            end
        end
    end

    // Scoreboard: mem_q holds in-flight fetches (stale = to be dropped),
    // exp_q mirrors the instruction buffer contents.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on && rstn) begin
                m_cv = !flush && !stall && (mem_q.size() + exp_q.size() < DEPTH);
                chk("cmd_valid", icb.cmd_valid, m_cv);
                chk("pc_ready", pc_ready, m_cv && icb.cmd_ready);
                chk("cmd_read", icb.cmd_read, 1'b1);
                if (m_cv) chk("cmd_addr", icb.cmd_addr, pc);
                chk("dec_valid", dec_valid, exp_q.size() != 0);
                if (icb.rsp_valid) chk("rsp_ready", icb.rsp_ready, 1'b1);

                if (dec_valid && dec_ready && exp_q.size() > 0) begin
                    m_e = exp_q.pop_front();
                    chk("dec_pc", dec_pc, m_e.pc);
                    chk("dec_instr", dec_instr, m_e.instr);
                    chk("dec_err", dec_err, m_e.err);
                end

                if (icb.rsp_valid && icb.rsp_ready && mem_q.size() > 0) begin
                    m_h = mem_q.pop_front();
                    if (!m_h.stale && !flush) begin
                        m_e.pc    = m_h.pc;
                        m_e.err   = (m_h.pc == ERR_PC);
                        m_e.instr = m_e.err ? 32'h0000_0013 : mem_word(m_h.pc);
                        exp_q.push_back(m_e);
                    end
                end

                if (flush) begin
                    exp_q.delete();
                    foreach (mem_q[i]) mem_q[i].stale = 1'b1;
                end

                if (icb.cmd_valid && icb.cmd_ready) begin
                    m_h.pc    = pc;
                    m_h.stale = 1'b0;
                    mem_q.push_back(m_h);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // PC stage: advance by 4 on each accepted command.
    task automatic run_pc(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        bit adv;
        while (got < n && cyc < budget) begin
            @(negedge clk);
            adv = pc_ready;
            tick();
            if (adv) begin
                pc = pc + 32'd4;
                got++;
            end
            cyc++;
        end
        chk("run_pc_cmds", got, n);
    endtask

    task automatic wait_dec(input int budget);
        int cyc = 0;
        @(negedge clk);
        while (!dec_valid && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("wait_dec_timeout", dec_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bit adv;
        pc = '0;
        flush = 1'b0;
        stall = 1'b0;
        dec_ready = 1'b0;
        icb.cmd_ready = 1'b0;
        rstn = 1'b0;

        // reset with random inputs
        repeat (5) begin
            tick();
            pc            = $urandom;
            flush         = 1'($urandom);
            stall         = 1'($urandom);
            dec_ready     = 1'($urandom);
            icb.cmd_ready = 1'($urandom);
        end
        @(negedge clk);
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_cmd_valid", icb.cmd_valid, 1'b0);
        chk("rst_pc_ready", pc_ready, 1'b0);
        chk("rst_rsp_ready", icb.rsp_ready, 1'b0);
        chk("rst_dec_instr", dec_instr, 32'h0);
        chk("rst_dec_pc", dec_pc, 32'h0);
        chk("rst_dec_err", dec_err, 1'b0);

        tick();
        pc = 32'h0;
        flush = 1'b0;
        stall = 1'b0;
        dec_ready = 1'b1;
        icb.cmd_ready = 1'b1;
        rstn = 1'b1;
        @(negedge clk);
        chk("rel_cmd_valid", icb.cmd_valid, 1'b0);
        chk("rel_dec_valid", dec_valid, 1'b0);

        // zero-wait fetch of 0x0, 0x4, 0x8
        tick();
        model_on = 1'b1;
        @(negedge clk);
        chk("first_cmd_valid", icb.cmd_valid, 1'b1);
        adv = pc_ready;
        tick();
        if (adv) pc = pc + 32'd4;
        run_pc(2, 20);
        stall = 1'b1;
        repeat (5) tick();

        // decode backpressure: credits run out after two fetches
        pc = 32'h0;
        dec_ready = 1'b0;
        stall = 1'b0;
        repeat (8) begin
            @(negedge clk);
            adv = pc_ready;
            tick();
            if (adv) pc = pc + 32'd4;
        end
        chk("bp_pc_hold", pc, 32'h8);
        @(negedge clk);
        chk("bp_cmd_blocked", icb.cmd_valid, 1'b0);
        chk("bp_pc_ready_low", pc_ready, 1'b0);
        tick();
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        @(negedge clk);
        chk("bp_cmd_restore", icb.cmd_valid, 1'b1);
        adv = pc_ready;
        tick();
        if (adv) pc = pc + 32'd4;
        stall = 1'b1;
        dec_ready = 1'b1;
        repeat (6) tick();

        // flush with two fetches in flight, redirect to 0x100
        pc = 32'h10;
        rsp_hold = 1'b1;
        stall = 1'b0;
        run_pc(2, 20);
        flush = 1'b1;
        pc = 32'h100;
        tick();
        flush = 1'b0;
        rsp_hold = 1'b0;
        run_pc(1, 20);
        stall = 1'b1;
        wait_dec(20);
        chk("redir_first_pc", dec_pc, 32'h100);
        repeat (4) tick();

        // bus error fetch
        pc = ERR_PC;
        stall = 1'b0;
        run_pc(1, 20);
        stall = 1'b1;
        wait_dec(20);
        chk("err_pc", dec_pc, ERR_PC);
        chk("err_flag", dec_err, 1'b1);
        chk("err_instr", dec_instr, 32'h0000_0013);
        repeat (3) tick();

        // flush coincident with response for 0x30, 0x34 still in flight
        pc = 32'h30;
        rsp_hold = 1'b1;
        stall = 1'b0;
        run_pc(2, 20);
        stall = 1'b1;
        rsp_hold = 1'b0;
        tick();
        flush = 1'b1;
        rsp_hold = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("coinc_drop_cnt", u_dut.drop_cnt, 1);
        chk("coinc_dec_valid", dec_valid, 1'b0);
        tick();
        rsp_hold = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        chk("coinc_drop_done", u_dut.drop_cnt, 0);
        chk("coinc_outstd", u_dut.outstd, 0);
        chk("coinc_buf_empty", dec_valid, 1'b0);

        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
